// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel enable from clk divider, h/v counters, syncs, active flag, frame markers.
// Latency: all outputs registered and mutually aligned; backpressure: none, free-running while en is high.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       pix_ce,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic       valid,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_E  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_E  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        HS_ON    = (HS_POL != 0);
    localparam logic        VS_ON    = (VS_POL != 0);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and CLK_DIV >= 1");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pix_ce_q, pix_ce_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             valid_q, valid_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             tick;
    logic [10:0]      h_e, v_e;

    always_comb begin
        tick        = (div_cnt_q == DIV_LAST);
        div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
        pix_ce_d    = tick;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;

        // The raster moves on the same edge that raises pix_ce.
        if (tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d     = '0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end

        if (!en) begin
            div_cnt_d   = '0;
            pix_ce_d    = 1'b0;
            h_cnt_d     = H_LAST;
            v_cnt_d     = V_LAST;
            frame_cnt_d = 8'hFF;
        end

        // Decode from next counters so flags line up with the registered counters.
        h_e           = {1'b0, h_cnt_d};
        v_e           = {1'b0, v_cnt_d};
        valid_d       = (h_e < H_ACT_E) && (v_e < V_ACT_E);
        hsync_d       = ((h_e >= HS_BEG) && (h_e < HS_END)) ? HS_ON : ~HS_ON;
        vsync_d       = ((v_e >= VS_BEG) && (v_e < VS_END)) ? VS_ON : ~VS_ON;
        line_start_d  = (h_cnt_d == 10'd0);
        frame_start_d = (h_cnt_d == 10'd0) && (v_cnt_d == 10'd0);

        if (!en) begin
            valid_d       = 1'b0;
            hsync_d       = ~HS_ON;
            vsync_d       = ~VS_ON;
            line_start_d  = 1'b0;
            frame_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q     <= '0;
            pix_ce_q      <= 1'b0;
            h_cnt_q       <= H_LAST;
            v_cnt_q       <= V_LAST;
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            valid_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'hFF;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pix_ce_q      <= pix_ce_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            valid_q       <= valid_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign pix_ce      = pix_ce_q;
    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign valid       = valid_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance for line-level timing, small raster
// instance (CLK_DIV=1, active-high hsync) for frame-level timing and frame counter wrap.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       val;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } px_t;

    logic       clk;
    logic       rst0, en0, rst1, en1;
    logic       pix_ce0, hsync0, vsync0, valid0, ls0, fs0;
    logic [9:0] h0, v0;
    logic [7:0] fc0;
    logic       pix_ce1, hsync1, vsync1, valid1, ls1, fs1;
    logic [9:0] h1, v1;
    logic [7:0] fc1;

    int  n_chk = 0;
    int  n_err = 0;
    px_t q0[$];
    px_t q1[$];
    bit  mon0_on = 0;
    bit  mon1_on = 0;
    bit  tally_on = 0;
    int  tally_idx = 0;
    int  valid_v0 = 0;
    int  hs_low_v0 = 0;
    int  hs_first = -1;
    int  ls_idx[$];

    vga_timing_gen dut0 (
        .clk(clk), .rst(rst0), .en(en0), .pix_ce(pix_ce0),
        .h_cnt(h0), .v_cnt(v0), .hsync(hsync0), .vsync(vsync0), .valid(valid0),
        .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(0), .CLK_DIV(1)
    ) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .pix_ce(pix_ce1),
        .h_cnt(h1), .v_cnt(v1), .hsync(hsync1), .vsync(vsync1), .valid(valid1),
        .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected pixel for the default 800x525 raster (hsync 656..751, vsync 490..491, both active low).
    function automatic px_t mk0(input int h, input int v);
        px_t p;
        p.h   = 10'(h);
        p.v   = 10'(v);
        p.val = (h < 640) && (v < 480);
        p.hs  = !((h >= 656) && (h < 752));
        p.vs  = !((v >= 490) && (v < 492));
        p.ls  = (h == 0);
        p.fs  = (h == 0) && (v == 0);
        p.fc  = 8'd0;
        return p;
    endfunction

    // Expected pixel for the 16x10 raster (hsync active high at 10..12, vsync active low at 7..8).
    function automatic px_t mk1(input int h, input int v, input int f);
        px_t p;
        p.h   = 10'(h);
        p.v   = 10'(v);
        p.val = (h < 8) && (v < 6);
        p.hs  = (h >= 10) && (h < 13);
        p.vs  = !((v >= 7) && (v < 9));
        p.ls  = (h == 0);
        p.fs  = (h == 0) && (v == 0);
        p.fc  = 8'(f % 256);
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rst0(input string tag);
        chk({tag, "_pix_ce"}, 32'(pix_ce0), 0);
        chk({tag, "_h"}, 32'(h0), 799);
        chk({tag, "_v"}, 32'(v0), 524);
        chk({tag, "_valid"}, 32'(valid0), 0);
        chk({tag, "_hsync"}, 32'(hsync0), 1);
        chk({tag, "_vsync"}, 32'(vsync0), 1);
        chk({tag, "_line_start"}, 32'(ls0), 0);
        chk({tag, "_frame_start"}, 32'(fs0), 0);
        chk({tag, "_frame_cnt"}, 32'(fc0), 255);
    endtask

    task automatic wait_empty(input int which, input int budget);
        int n = 0;
        while (((which == 0) ? q0.size() : q1.size()) != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_chk++;
        if (((which == 0) ? q0.size() : q1.size()) != 0) begin
            n_err++;
            $display("FAIL sb%0d_timeout: %0d entries left after %0d clks", which,
                     (which == 0) ? q0.size() : q1.size(), budget);
            if (which == 0) q0.delete(); else q1.delete();
        end
    endtask

    always @(negedge clk) begin : mon0
        px_t e, a;
        if (mon0_on && pix_ce0) begin
            a = '{h: h0, v: v0, val: valid0, hs: hsync0, vs: vsync0, ls: ls0, fs: fs0, fc: fc0};
            n_chk++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL sb0_unexpected: pixel h=%0d v=%0d with no expectation", a.h, a.v);
            end else begin
                e = q0.pop_front();
                if (a !== e) begin
                    n_err++;
                    $display("FAIL sb0_pixel: got h=%0d v=%0d val=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d expected h=%0d v=%0d val=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
                             a.h, a.v, a.val, a.hs, a.vs, a.ls, a.fs, a.fc,
                             e.h, e.v, e.val, e.hs, e.vs, e.ls, e.fs, e.fc);
                end
            end
            if (tally_on) begin
                if (a.v == 10'd0) begin
                    if (a.val) valid_v0++;
                    if (!a.hs) begin
                        hs_low_v0++;
                        if (hs_first < 0) hs_first = int'(a.h);
                    end
                end
                if (a.ls) ls_idx.push_back(tally_idx);
                tally_idx++;
            end
        end
    end

    always @(negedge clk) begin : mon1
        px_t e, a;
        if (mon1_on) begin
            a = '{h: h1, v: v1, val: valid1, hs: hsync1, vs: vsync1, ls: ls1, fs: fs1, fc: fc1};
            n_chk++;
            if (pix_ce1 !== 1'b1) begin
                n_err++;
                $display("FAIL sb1_pix_ce: got %0b expected 1 at h=%0d v=%0d", pix_ce1, a.h, a.v);
            end else if (q1.size() == 0) begin
                n_err++;
                $display("FAIL sb1_unexpected: pixel h=%0d v=%0d with no expectation", a.h, a.v);
            end else begin
                e = q1.pop_front();
                if (a !== e) begin
                    n_err++;
                    $display("FAIL sb1_pixel: got h=%0d v=%0d val=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d expected h=%0d v=%0d val=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
                             a.h, a.v, a.val, a.hs, a.vs, a.ls, a.fs, a.fc,
                             e.h, e.v, e.val, e.hs, e.vs, e.ls, e.fs, e.fc);
                end
            end
        end
    end

    initial begin
        rst0 = 1'b1; en0 = 1'b1;
        rst1 = 1'b1; en1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_rst0("reset0");
        chk("reset1_pix_ce", 32'(pix_ce1), 0);
        chk("reset1_h", 32'(h1), 15);
        chk("reset1_v", 32'(v1), 9);
        chk("reset1_hsync", 32'(hsync1), 0);
        chk("reset1_vsync", 32'(vsync1), 1);
        chk("reset1_frame_cnt", 32'(fc1), 255);

        // First line plus the next line up to h=700, then drop en mid-hsync.
        for (int h = 0; h < 800; h++) q0.push_back(mk0(h, 0));
        for (int h = 0; h <= 700; h++) q0.push_back(mk0(h, 1));
        tally_on = 1;
        mon0_on  = 1;
        rst0     = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("pix_ce_edge%0d", k), 32'(pix_ce0), (k % 2 == 0) ? 1 : 0);
        end
        wait_empty(0, 4000);
        tally_on = 0;
        mon0_on  = 0;
        chk("line_valid_count", valid_v0, 640);
        chk("line_hsync_low_count", hs_low_v0, 96);
        chk("line_hsync_first_h", hs_first, 656);
        chk("line_start_count", ls_idx.size(), 2);
        chk("line_period", (ls_idx.size() >= 2) ? (ls_idx[1] - ls_idx[0]) : -1, 800);

        en0 = 1'b0;
        @(posedge clk);
        #1;
        chk_rst0("en_low");
        en0 = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_edge1_pix_ce", 32'(pix_ce0), 0);
        chk("restart_edge1_h", 32'(h0), 799);
        for (int h = 0; h <= 700; h++) q0.push_back(mk0(h, 0));
        mon0_on = 1;
        wait_empty(0, 2000);
        mon0_on = 0;

        // Asynchronous reset lands between clock edges.
        chk("pre_rst_hsync", 32'(hsync0), 0);
        #2;
        rst0 = 1'b1;
        #1;
        chk("async_rst_hsync", 32'(hsync0), 1);
        chk("async_rst_h", 32'(h0), 799);
        chk("async_rst_valid", 32'(valid0), 0);

        // Small raster: 257 frames of 16x10 so frame_cnt runs 0..255 and wraps to 0.
        @(posedge clk);
        #1;
        for (int f = 0; f < 257; f++)
            for (int v = 0; v < 10; v++)
                for (int h = 0; h < 16; h++)
                    q1.push_back(mk1(h, v, f));
        rst1 = 1'b0;
        @(posedge clk);
        #1;
        mon1_on = 1;
        wait_empty(1, 45000);
        mon1_on = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
